rf_access_arbiter: RTL
======================

// Module: rf_access_arbiter
// PURPOSE
//  Sits between the warp issue stage / writeback units and register_block; shares its 2 read ports,
//  1 write port and single warp_selector among one operand-read requester and NUM_WB writeback sources.
//  Every cycle it grants at most one read and one write, both to the same warp.
//  It drives the register_block controls, captures read data, forwards same-cycle writes, and bounds read starvation.
// PARAMETERS
//  NUM_WARPS   8   warps in register_block; WARP_W = $clog2(NUM_WARPS)
//  NUM_LANES   16  lanes per warp (mask width)
//  NUM_REGS    16  registers per lane; REG_W = $clog2(NUM_REGS)
//  DATA_W      64  register width
//  NUM_WB      2   writeback sources (0=ALU, 1=MEM)
//  STARVE_LIM  4   consecutive denied cycles before a read overrides writes (>=1)
// PORTS
//  clk              in   1                      clock, rising edge
//  rst              in   1                      asynchronous, active-high reset
//  rd_req_valid     in   1                      operand read request
//  rd_req_ready     out  1                      read granted this cycle
//  rd_req_warp      in   WARP_W                 warp of read
//  rd_req_rs0       in   REG_W                  source reg, port 0
//  rd_req_rs1       in   REG_W                  source reg, port 1
//  rd_req_mask      in   NUM_LANES              active lanes
//  rd_rsp_valid     out  1                      read data valid (no backpressure)
//  rd_rsp_data0     out  NUM_LANES*DATA_W       rs0 data, lane i at [i*DATA_W +: DATA_W]
//  rd_rsp_data1     out  NUM_LANES*DATA_W       rs1 data
//  wb_req_valid     in   NUM_WB                 writeback request per source
//  wb_req_ready     out  NUM_WB                 one-hot (or 0) write grant
//  wb_req_warp      in   NUM_WB*WARP_W          warp per source
//  wb_req_rd        in   NUM_WB*REG_W           dest reg per source
//  wb_req_mask      in   NUM_WB*NUM_LANES       lane mask per source
//  wb_req_data      in   NUM_WB*NUM_LANES*DATA_W data per source
//  rf_read_en_0/1   out  NUM_LANES              register_block read enables
//  rf_raddr_0/1     out  REG_W                  register_block read addresses
//  rf_write_en      out  NUM_LANES              register_block write enables
//  rf_waddr         out  REG_W                  register_block write address
//  rf_wdata         out  NUM_LANES*DATA_W       register_block write data
//  rf_warp_selector out  WARP_W                 register_block warp select
//  rf_rdata_0/1     in   NUM_LANES*DATA_W       register_block read data (combinational)
// BEHAVIOUR
//  Reset: rd_rsp_valid=0, rd_rsp_data0/1=0, rr_ptr=0, starve_cnt=0, last_warp=0; all grants 0 while rst high.
//  Write candidate W: round-robin over valid sources starting at rr_ptr; rr_ptr<=W+1 (mod NUM_WB) only when W granted.
//  Grant rules each cycle (combinational from inputs + state):
//   - no rd_req_valid: W granted if present.
//   - rd valid, no W, or W warp == rd warp: read and W both granted.
//   - warps differ, starve_cnt < STARVE_LIM: W granted, read denied, starve_cnt++.
//   - warps differ, starve_cnt == STARVE_LIM: read granted, all wb_req_ready=0.
//   - starve_cnt clears to 0 on any read grant; saturates at STARVE_LIM.
//  RF drive: read granted -> rf_read_en_0/1=rd_req_mask, rf_raddr_0/1=rs0/rs1, else enables 0.
//   Write granted -> rf_write_en=mask(W), rf_waddr=rd(W), rf_wdata=data(W), else rf_write_en=0.
//   rf_warp_selector = granted warp, else last_warp; last_warp updates on every grant.
//  Write commits at the clock edge ending the grant cycle; handshake completes when valid&&ready.
//  Read response: rd_rsp_valid=1 exactly one cycle after a read grant, data registered at that edge.
//   Lanes outside rd_req_mask return 0.
//   Forwarding (write-before-read): same-cycle granted write to same warp with rd==rs0 (resp. rs1)
//   replaces that port's data on lanes in wb mask & rd mask.
//  Mask 0 requests are still granted/consumed; they cause no RF write / return all-zero data.
//  Reset asserted mid-operation: pending response dropped (rd_rsp_valid=0 next cycle), state to reset values.
// TESTING
//  T1 single wb src0 warp 3 r5 mask FFFF data i*0x11 -> rf_write_en=FFFF, selector=3; later read r5 warp 3 returns data, rsp 1 cycle after ready.
//  T2 both wb valid continuously, no reads -> grants alternate 0,1,0,1 starting with src0 after reset.
//  T3 read warp 2, src0 wb warp 5 valid every cycle, STARVE_LIM=4 -> read denied 4 cycles, granted on 5th with wb_req_ready=0, starve_cnt back to 0.
//  T4 read warp 1 rs0=rs1=r7 mask 00FF with same-cycle wb warp 1 r7 mask 0F0F data AA.. -> lanes 0-3 return AA.., lanes 4-7 old value, lanes 8-15 zero.
//  T5 rst asserted the cycle after a read grant -> rd_rsp_valid stays 0, rr_ptr=0, first post-reset grant to src0.
//  T6 sweep all 8 warps x 16 regs via src1 random data, read back each -> all lanes match, no X on outputs.

Source files
------------

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter
//   Shares the register_block's two read ports, single write port and single
//   warp selector between one operand-read requester and NUM_WB writeback
//   sources. At most one read and one write are granted per cycle, and both
//   always target the same warp because the register_block has only one warp
//   selector. Writebacks normally win a warp conflict; a read that has been
//   denied STARVE_LIM cycles in a row takes the port and blocks all writes for
//   that cycle. A write granted in the same cycle as a read to the same
//   register is forwarded into the read response (write-before-read).

module rf_access_arbiter #(
   parameter  int NUM_WARPS  = 8,
   parameter  int NUM_LANES  = 16,
   parameter  int NUM_REGS   = 16,
   parameter  int DATA_W     = 64,
   parameter  int NUM_WB     = 2,
   parameter  int STARVE_LIM = 4,
   localparam int WARP_W     = $clog2(NUM_WARPS),
   localparam int REG_W      = $clog2(NUM_REGS)
) (
   input  logic                                clk,
   input  logic                                rst,

   // operand read requester
   input  logic                                rd_req_valid,
   output logic                                rd_req_ready,
   input  logic [WARP_W-1:0]                   rd_req_warp,
   input  logic [REG_W-1:0]                    rd_req_rs0,
   input  logic [REG_W-1:0]                    rd_req_rs1,
   input  logic [NUM_LANES-1:0]                rd_req_mask,
   output logic                                rd_rsp_valid,
   output logic [NUM_LANES*DATA_W-1:0]         rd_rsp_data0,
   output logic [NUM_LANES*DATA_W-1:0]         rd_rsp_data1,

   // writeback sources (0 = ALU, 1 = MEM)
   input  logic [NUM_WB-1:0]                   wb_req_valid,
   output logic [NUM_WB-1:0]                   wb_req_ready,
   input  logic [NUM_WB*WARP_W-1:0]            wb_req_warp,
   input  logic [NUM_WB*REG_W-1:0]             wb_req_rd,
   input  logic [NUM_WB*NUM_LANES-1:0]         wb_req_mask,
   input  logic [NUM_WB*NUM_LANES*DATA_W-1:0]  wb_req_data,

   // register_block interface
   output logic [NUM_LANES-1:0]                rf_read_en_0,
   output logic [NUM_LANES-1:0]                rf_read_en_1,
   output logic [REG_W-1:0]                    rf_raddr_0,
   output logic [REG_W-1:0]                    rf_raddr_1,
   output logic [NUM_LANES-1:0]                rf_write_en,
   output logic [REG_W-1:0]                    rf_waddr,
   output logic [NUM_LANES*DATA_W-1:0]         rf_wdata,
   output logic [WARP_W-1:0]                   rf_warp_selector,
   input  logic [NUM_LANES*DATA_W-1:0]         rf_rdata_0,
   input  logic [NUM_LANES*DATA_W-1:0]         rf_rdata_1
);

   localparam int WB_W    = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
   localparam int CNT_W   = $clog2(STARVE_LIM + 1);
   localparam int LANE_DW = NUM_LANES * DATA_W;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [WB_W-1:0]   rr_ptr;      // first source examined next cycle
   logic [CNT_W-1:0]  starve_cnt;  // consecutive cycles the read lost a warp conflict
   logic [WARP_W-1:0] last_warp;   // selector value held while nothing is granted

   // ------------------------------------------------------------------
   // Write candidate and its fields
   // ------------------------------------------------------------------
   logic                 w_found;
   logic [WB_W-1:0]      w_sel;
   logic [WB_W-1:0]      rr_next;
   logic [WARP_W-1:0]    w_warp;
   logic [REG_W-1:0]     w_rd;
   logic [NUM_LANES-1:0] w_mask;
   logic [LANE_DW-1:0]   w_data;

   // Round-robin search over valid writeback sources, starting at rr_ptr.
   always_comb begin
      // NOTE: every variable assigned in a combinational block gets a default
      // first, so no path through the block leaves it unassigned (no latch).
      w_found = 1'b0;
      w_sel   = '0;
      for (int k = 0; k < NUM_WB; k++) begin
         if (!w_found && wb_req_valid[(int'(rr_ptr) + k) % NUM_WB]) begin
            w_found = 1'b1;
            w_sel   = WB_W'((int'(rr_ptr) + k) % NUM_WB);
         end
      end
   end

   assign rr_next = WB_W'((int'(w_sel) + 1) % NUM_WB);
   assign w_warp  = wb_req_warp[w_sel*WARP_W +: WARP_W];
   assign w_rd    = wb_req_rd[w_sel*REG_W +: REG_W];
   assign w_mask  = wb_req_mask[w_sel*NUM_LANES +: NUM_LANES];
   assign w_data  = wb_req_data[w_sel*LANE_DW +: LANE_DW];

   // ------------------------------------------------------------------
   // Grant decision
   // ------------------------------------------------------------------
   logic rd_grant;
   logic wb_grant;
   logic starve_inc;

   // Decide read/write grants; a reset in progress suppresses everything.
   always_comb begin
      rd_grant   = 1'b0;
      wb_grant   = 1'b0;
      starve_inc = 1'b0;
      if (!rst) begin
         if (!rd_req_valid) begin
            wb_grant = w_found;
         end else if (!w_found || (w_warp == rd_req_warp)) begin
            // No conflict on the warp selector: both proceed.
            rd_grant = 1'b1;
            wb_grant = w_found;
         end else if (starve_cnt < CNT_W'(STARVE_LIM)) begin
            wb_grant   = 1'b1;
            starve_inc = 1'b1;
         end else begin
            // Read has waited long enough: it owns the selector this cycle.
            rd_grant = 1'b1;
         end
      end
   end

   // One-hot write grant to the selected source.
   always_comb begin
      wb_req_ready = '0;
      if (wb_grant) begin
         wb_req_ready[w_sel] = 1'b1;
      end
   end

   assign rd_req_ready = rd_grant;

   // ------------------------------------------------------------------
   // register_block drive
   // ------------------------------------------------------------------
   assign rf_read_en_0 = rd_grant ? rd_req_mask : '0;
   assign rf_read_en_1 = rd_grant ? rd_req_mask : '0;
   assign rf_raddr_0   = rd_req_rs0;
   assign rf_raddr_1   = rd_req_rs1;
   assign rf_write_en  = wb_grant ? w_mask : '0;
   assign rf_waddr     = w_rd;
   assign rf_wdata     = w_data;

   // Selector follows the granted warp; it parks on the last one when idle.
   always_comb begin
      rf_warp_selector = last_warp;
      if (rd_grant) begin
         rf_warp_selector = rd_req_warp;
      end else if (wb_grant) begin
         rf_warp_selector = w_warp;
      end
   end

   // ------------------------------------------------------------------
   // Read response assembly with same-cycle write forwarding
   // ------------------------------------------------------------------
   logic               fwd0;
   logic               fwd1;
   logic [LANE_DW-1:0] rsp_next0;
   logic [LANE_DW-1:0] rsp_next1;

   assign fwd0 = rd_grant && wb_grant && (w_warp == rd_req_warp) && (w_rd == rd_req_rs0);
   assign fwd1 = rd_grant && wb_grant && (w_warp == rd_req_warp) && (w_rd == rd_req_rs1);

   // Per lane: zero outside the read mask, forwarded write data where the
   // granted write covers the lane, otherwise the register_block data.
   always_comb begin
      rsp_next0 = '0;
      rsp_next1 = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (rd_req_mask[i]) begin
            rsp_next0[i*DATA_W +: DATA_W] = (fwd0 && w_mask[i]) ? w_data[i*DATA_W +: DATA_W]
                                                                 : rf_rdata_0[i*DATA_W +: DATA_W];
            rsp_next1[i*DATA_W +: DATA_W] = (fwd1 && w_mask[i]) ? w_data[i*DATA_W +: DATA_W]
                                                                 : rf_rdata_1[i*DATA_W +: DATA_W];
         end
      end
   end

   // ------------------------------------------------------------------
   // Sequential state
   // ------------------------------------------------------------------

   // Response register, round-robin pointer, starvation counter, parked warp.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_rsp_valid <= 1'b0;
         rd_rsp_data0 <= '0;
         rd_rsp_data1 <= '0;
         rr_ptr       <= '0;
         starve_cnt   <= '0;
         last_warp    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values, independent of statement order.
         rd_rsp_valid <= rd_grant;
         if (rd_grant) begin
            rd_rsp_data0 <= rsp_next0;
            rd_rsp_data1 <= rsp_next1;
         end

         if (wb_grant) begin
            rr_ptr <= rr_next;
         end

         if (rd_grant) begin
            starve_cnt <= '0;
         end else if (starve_inc) begin
            starve_cnt <= starve_cnt + 1'b1;
         end

         if (rd_grant || wb_grant) begin
            last_warp <= rf_warp_selector;
         end
      end
   end

endmodule
